// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter and its 4-bit ALU core.
package alu_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned RES_W  = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Request as captured at the grant handshake.
    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [2:0]        op;
        logic              id;
    } req_t;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Two request channels and one tagged response channel around the shared ALU.
interface alu_req_arbiter_if;
    import alu_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [OPND_W-1:0] req0_a;
    logic [OPND_W-1:0] req0_b;
    logic [2:0]        req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [OPND_W-1:0] req1_a;
    logic [OPND_W-1:0] req1_b;
    logic [2:0]        req1_op;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [RES_W-1:0]  rsp_data;

    // Requesters and response consumer.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
    );

    // Arbiter.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU; operands zero-extended, result truncated to 8 bits.
module alu4_core
    import alu_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [2:0]        op,
    output logic [RES_W-1:0]  y
);

    logic [RES_W-1:0] a_x;
    logic [RES_W-1:0] b_x;

    assign a_x = {{(RES_W-OPND_W){1'b0}}, a};
    assign b_x = {{(RES_W-OPND_W){1'b0}}, b};

    // Opcode decode.
    always_comb begin
        y = '0;
        unique case (op)
            OP_ADD:  y = a_x + b_x;
            OP_SUB:  y = a_x - b_x;
            OP_AND:  y = a_x & b_x;
            OP_OR:   y = a_x | b_x;
            OP_XOR:  y = a_x ^ b_x;
            OP_NOT:  y = ~a_x;
            OP_SHR:  y = a_x >> 1;
            OP_SHL:  y = a_x << 1;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sequencing two requesters through one ALU core.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_req_arbiter_if.slave bus,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1,
    output logic             busy
);

    state_e           state_q, state_d;
    req_t             req_q, req_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [RES_W-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             grant_id;
    logic             grant0;
    logic             grant1;
    logic [RES_W-1:0] alu_y;

    alu4_core u_alu (
        .a  (req_q.a),
        .b  (req_q.b),
        .op (req_q.op),
        .y  (alu_y)
    );

    // Grant choice: sole requester wins, a tie goes to whoever did not win last.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
        grant0 = bus.req0_valid && !grant_id;
        grant1 = bus.req1_valid && grant_id;
    end

    // Next-state, handshake and response sequencing.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        last_grant_d   = last_grant_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_data_d     = rsp_data_q;
        cnt0_d         = cnt0_q;
        cnt1_d         = cnt1_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bus.req0_ready = grant0;
                bus.req1_ready = grant1;
                if (grant0 || grant1) begin
                    req_d.a      = grant_id ? bus.req1_a  : bus.req0_a;
                    req_d.b      = grant_id ? bus.req1_b  : bus.req0_b;
                    req_d.op     = grant_id ? bus.req1_op : bus.req0_op;
                    req_d.id     = grant_id;
                    last_grant_d = grant_id;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d  = alu_y;
                rsp_id_d    = req_q.id;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_id_q) begin
                        cnt1_d = cnt1_q + 1'b1;
                    end else begin
                        cnt0_d = cnt0_q + 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_q        <= '0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign done_cnt0     = cnt0_q;
    assign done_cnt1     = cnt1_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: queue-driven requesters, latency-based reference model,
// directed scenarios with literal expectations.
module tb_alu_req_arbiter;

    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] done_cnt0;
    logic [CNT_W-1:0] done_cnt1;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_on = 1'b0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];

    alu_req_arbiter_if bus ();

    alu_req_arbiter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .done_cnt0 (done_cnt0),
        .done_cnt1 (done_cnt1),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu_ref(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = 255 - a;
            6:       r = a / 2;
            default: r = a * 2;
        endcase
        return r[7:0];
    endfunction

    // Requesters: present the head of their queue, pop it after a handshake edge.
    initial begin : requester0
        bit hs;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        forever begin
            @(negedge clk);
            hs = bus.req0_valid && bus.req0_ready;
            @(posedge clk);
            #1;
            if (hs) void'(q0.pop_front());
            bus.req0_valid = (q0.size() > 0);
            if (q0.size() > 0) begin
                bus.req0_a = q0[0].a; bus.req0_b = q0[0].b; bus.req0_op = q0[0].op;
            end
        end
    end

    initial begin : requester1
        bit hs;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        forever begin
            @(negedge clk);
            hs = bus.req1_valid && bus.req1_ready;
            @(posedge clk);
            #1;
            if (hs) void'(q1.pop_front());
            bus.req1_valid = (q1.size() > 0);
            if (q1.size() > 0) begin
                bus.req1_a = q1[0].a; bus.req1_b = q1[0].b; bus.req1_op = q1[0].op;
            end
        end
    end

    // Reference model: one transaction in flight; result visible one cycle after
    // acceptance and held until consumed. Checked every cycle at the falling edge.
    initial begin : compare
        bit v0, v1, g, er0, er1, ev, m_pend, m_last, m_id;
        int m_age;
        int m_cnt[2];
        logic [7:0] m_data;
        m_pend = 0; m_last = 1; m_age = 0; m_id = 0; m_data = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        forever begin
            @(negedge clk);
            v0 = bus.req0_valid; v1 = bus.req1_valid;
            er0 = 0; er1 = 0; g = 0;
            if (!m_pend) begin
                g = (v0 && v1) ? !m_last : v1;
                er0 = v0 && !g;
                er1 = v1 && g;
            end
            ev = m_pend && (m_age >= 1);
            if (model_on) begin
                chk("req0_ready", bus.req0_ready, er0);
                chk("req1_ready", bus.req1_ready, er1);
                chk("both_ready", bus.req0_ready && bus.req1_ready, 0);
                chk("rsp_valid", bus.rsp_valid, ev);
                chk("busy", busy, m_pend);
                chk("done_cnt0", done_cnt0, m_cnt[0]);
                chk("done_cnt1", done_cnt1, m_cnt[1]);
                if (ev) begin
                    chk("rsp_id", bus.rsp_id, m_id);
                    chk("rsp_data", bus.rsp_data, m_data);
                end
            end
            if (rst) begin
                m_pend = 0; m_last = 1; m_age = 0; m_cnt[0] = 0; m_cnt[1] = 0;
            end else if (!m_pend) begin
                if (er0 || er1) begin
                    m_pend = 1; m_age = 0; m_id = er1; m_last = er1;
                    m_data = er1 ? alu_ref(bus.req1_a, bus.req1_b, bus.req1_op)
                                 : alu_ref(bus.req0_a, bus.req0_b, bus.req0_op);
                end
            end else if (ev && bus.rsp_ready) begin
                m_pend = 0;
                m_cnt[m_id] = (m_cnt[m_id] + 1) % (1 << CNT_W);
            end else begin
                m_age++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push0(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        txn_t t;
        t.a = a; t.b = b; t.op = op;
        q0.push_back(t);
    endtask

    task automatic push1(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        txn_t t;
        t.a = a; t.b = b; t.op = op;
        q1.push_back(t);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Waits (bounded) for a response handshake, then steps past the consuming edge.
    task automatic wait_rsp(output logic id, output logic [7:0] data);
        int n = 0;
        while (!(bus.rsp_valid && bus.rsp_ready) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("rsp_timeout", 1, 0);
        id   = bus.rsp_id;
        data = bus.rsp_data;
        step();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.rsp_valid && n < 40) begin
            step();
            n++;
        end
        chk("rsp_valid_seen", bus.rsp_valid, 1);
    endtask

    initial begin : main
        logic       id;
        logic [7:0] data;
        int         n;
        int         wrap_exp[5];
        wrap_exp = '{1, 2, 3, 0, 1};
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        step();
        step();
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt0", done_cnt0, 0);
        chk("rst_cnt1", done_cnt1, 0);
        rst = 1'b0;
        step();
        model_on = 1'b1;

        // Single request: 3 - 5 wraps to 8'hFE.
        bus.rsp_ready = 1'b1;
        push0(4'd3, 4'd5, 3'b001);
        wait_rsp(id, data);
        chk("t1_id", id, 0);
        chk("t1_data", data, 8'hFE);
        chk("t1_cnt0", done_cnt0, 1);

        // Simultaneous requests after reset: requester 0 wins the tie.
        do_reset();
        push0(4'd7, 4'd8, 3'b000);
        push1(4'hA, 4'd0, 3'b101);
        wait_rsp(id, data);
        chk("t2_first_id", id, 0);
        chk("t2_first_data", data, 8'h0F);
        wait_rsp(id, data);
        chk("t2_second_id", id, 1);
        chk("t2_second_data", data, 8'hF5);

        // Continuous contention alternates owners.
        do_reset();
        push0(4'd1, 4'd2, 3'b000); push0(4'd5, 4'd3, 3'b001); push0(4'hF, 4'hF, 3'b010);
        push1(4'hC, 4'd3, 3'b011); push1(4'd6, 4'd5, 3'b100); push1(4'd8, 4'd0, 3'b110);
        for (int i = 0; i < 6; i++) begin
            wait_rsp(id, data);
            chk("t3_alt_id", id, i % 2);
        end
        chk("t3_cnt0", done_cnt0, 3);
        chk("t3_cnt1", done_cnt1, 3);

        // Backpressure holds the response; pending requester 0 is not accepted.
        do_reset();
        bus.rsp_ready = 1'b0;
        push1(4'd9, 4'd0, 3'b111);
        n = 0;
        while (!busy && n < 20) begin step(); n++; end
        chk("t4_busy", busy, 1);
        push0(4'd1, 4'd1, 3'b000);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", bus.rsp_valid, 1);
            chk("t4_hold_data", bus.rsp_data, 8'h12);
            chk("t4_hold_id", bus.rsp_id, 1);
            chk("t4_no_ready0", bus.req0_ready, 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("t4_released", bus.rsp_valid, 0);
        chk("t4_cnt1", done_cnt1, 1);
        wait_rsp(id, data);
        chk("t4_req0_id", id, 0);
        chk("t4_req0_data", data, 8'h02);

        // Reset while executing.
        do_reset();
        push0(4'd4, 4'd4, 3'b000);
        n = 0;
        while (!bus.req0_ready && n < 20) begin step(); n++; end
        chk("t5_accept", bus.req0_ready, 1);
        step();
        chk("t5_exec_busy", busy, 1);
        rst = 1'b1;
        step();
        chk("t5_exec_rsp_valid", bus.rsp_valid, 0);
        chk("t5_exec_busy_clr", busy, 0);
        chk("t5_exec_cnt0", done_cnt0, 0);
        rst = 1'b0;
        step();

        // Reset while a response is pending.
        bus.rsp_ready = 1'b0;
        push0(4'd2, 4'd2, 3'b011);
        wait_valid();
        rst = 1'b1;
        step();
        chk("t5_resp_rsp_valid", bus.rsp_valid, 0);
        chk("t5_resp_busy", busy, 0);
        chk("t5_resp_cnt0", done_cnt0, 0);
        chk("t5_resp_cnt1", done_cnt1, 0);
        rst = 1'b0;
        step();
        bus.rsp_ready = 1'b1;
        push0(4'd6, 4'd3, 3'b010);
        wait_rsp(id, data);
        chk("t5_fresh_id", id, 0);
        chk("t5_fresh_data", data, 8'h02);
        chk("t5_fresh_cnt0", done_cnt0, 1);

        // Counter wrap on a 2-bit counter.
        do_reset();
        chk("t6_cnt0_start", done_cnt0, 0);
        for (int i = 0; i < 5; i++) begin
            push0(4'(i + 1), 4'(2 * i), 3'b100);
            wait_rsp(id, data);
            chk("t6_cnt0_wrap", done_cnt0, wrap_exp[i]);
        end

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
